// File: rtl/seq_pkg.sv
// seq_pkg: shared types and defaults for the sequence memory / playback slice.
//   seq_state_t : playback FSM states
//   seq_idx_t   : entry index at the default depth
//   max2()      : elaboration-time helper for counter sizing
package seq_pkg;

   localparam int SEQ_DATA_W = 8;
   localparam int SEQ_DEPTH  = 4;
   localparam int SEQ_IDX_W  = $clog2(SEQ_DEPTH);

   typedef logic [SEQ_IDX_W-1:0] seq_idx_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHOW,
      S_GAP,
      S_DONE
   } seq_state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seq_mem_regfile.sv
// seq_mem_regfile: DEPTH x DATA_W register file with per-entry written flags.
//   wr_en/wr_idx/wr_data : one write per cycle, sets the entry's valid bit
//   clr                  : clears all valid bits (data untouched); a same-cycle
//                          write still sets its own bit
//   rd_idx/rd_data       : combinational random-access read
//   fetch_idx/fetch_data : combinational read used by the playback engine
//   valid                : per-entry written flags
module seq_mem_regfile
   import seq_pkg::*;
#(
   parameter int DATA_W = SEQ_DATA_W,
   parameter int DEPTH  = SEQ_DEPTH,
   parameter int IDX_W  = SEQ_IDX_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data,
   input  logic [IDX_W-1:0]  fetch_idx,
   output logic [DATA_W-1:0] fetch_data,
   output logic [DEPTH-1:0]  valid
);

   logic [DEPTH-1:0][DATA_W-1:0] mem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem   <= '0;
         valid <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            // Write wins over clear for its own entry.
            if (wr_en && (wr_idx == IDX_W'(i))) begin
               mem[i]   <= wr_data;
               valid[i] <= 1'b1;
            end else if (clr) begin
               valid[i] <= 1'b0;
            end
         end
      end
   end

   // Registered contents only: a same-cycle write is seen after the edge.
   assign rd_data    = mem[rd_idx];
   assign fetch_data = mem[fetch_idx];

endmodule

// File: rtl/seq_mem_playback.sv
// seq_mem_playback: four-entry sequence memory with random read and timed
// playback of the stored pattern.
//   MEM_IN/MEM_LOAD/MEM_LOAD_VAL : write port; MEM_CLR clears valid flags
//   RD_IDX/RD_DATA               : random-access read, MEM_VALID flags
//   en_PLAY/PLAY_LEN             : start/hold playback, length sampled at start
//   PLAY_OUT/PLAY_VALID/PLAY_IDX : displayed entry (0 when not showing)
//   complete_PLAY                : run finished, held until en_PLAY drops
module seq_mem_playback
   import seq_pkg::*;
#(
   parameter int DATA_W      = SEQ_DATA_W,
   parameter int DEPTH       = SEQ_DEPTH,
   parameter int IDX_W       = SEQ_IDX_W,
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] MEM_IN,
   input  logic              MEM_LOAD,
   input  logic [IDX_W-1:0]  MEM_LOAD_VAL,
   input  logic              MEM_CLR,
   input  logic [IDX_W-1:0]  RD_IDX,
   output logic [DATA_W-1:0] RD_DATA,
   output logic [DEPTH-1:0]  MEM_VALID,
   input  logic              en_PLAY,
   input  logic [IDX_W:0]    PLAY_LEN,
   output logic [DATA_W-1:0] PLAY_OUT,
   output logic              PLAY_VALID,
   output logic [IDX_W-1:0]  PLAY_IDX,
   output logic              complete_PLAY
);

   localparam int CNT_MAX = max2(HOLD_CYCLES, GAP_CYCLES);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W:0]   DEPTH_L   = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0]   ONE_L     = (IDX_W+1)'(1);

   seq_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  last_idx;
   logic [IDX_W-1:0]  fetch_idx;
   logic [DATA_W-1:0] fetch_data;
   logic [IDX_W:0]    len_clamp;

   seq_mem_regfile #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_regfile (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (MEM_LOAD),
      .wr_idx     (MEM_LOAD_VAL),
      .wr_data    (MEM_IN),
      .clr        (MEM_CLR),
      .rd_idx     (RD_IDX),
      .rd_data    (RD_DATA),
      .fetch_idx  (fetch_idx),
      .fetch_data (fetch_data),
      .valid      (MEM_VALID)
   );

   assign len_clamp = (PLAY_LEN > DEPTH_L) ? DEPTH_L : PLAY_LEN;

   // Entry that becomes visible on the next SHOW entry: 0 from IDLE, idx+1
   // from GAP. Captured into PLAY_OUT on that edge and held for the show.
   assign fetch_idx = (state == S_GAP) ? idx + IDX_W'(1) : '0;

   assign PLAY_IDX = idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         idx           <= '0;
         last_idx      <= '0;
         PLAY_OUT      <= '0;
         PLAY_VALID    <= 1'b0;
         complete_PLAY <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (en_PLAY) begin
                  cnt <= '0;
                  idx <= '0;
                  if (len_clamp == '0) begin
                     state         <= S_DONE;
                     complete_PLAY <= 1'b1;
                  end else begin
                     // len is 1..DEPTH here, so len-1 fits the index width.
                     last_idx   <= IDX_W'(len_clamp - ONE_L);
                     state      <= S_SHOW;
                     PLAY_OUT   <= fetch_data;
                     PLAY_VALID <= 1'b1;
                  end
               end
            end
            S_SHOW: begin
               if (!en_PLAY) begin
                  state      <= S_IDLE;
                  cnt        <= '0;
                  idx        <= '0;
                  PLAY_OUT   <= '0;
                  PLAY_VALID <= 1'b0;
               end else if (cnt == HOLD_LAST) begin
                  cnt        <= '0;
                  PLAY_OUT   <= '0;
                  PLAY_VALID <= 1'b0;
                  if (idx == last_idx) begin
                     state         <= S_DONE;
                     complete_PLAY <= 1'b1;
                  end else begin
                     state <= S_GAP;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_GAP: begin
               if (!en_PLAY) begin
                  state <= S_IDLE;
                  cnt   <= '0;
                  idx   <= '0;
               end else if (cnt == GAP_LAST) begin
                  cnt        <= '0;
                  idx        <= fetch_idx;
                  state      <= S_SHOW;
                  PLAY_OUT   <= fetch_data;
                  PLAY_VALID <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (!en_PLAY) begin
                  state         <= S_IDLE;
                  idx           <= '0;
                  complete_PLAY <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mem_playback.sv
// tb_seq_mem_playback: directed, table-driven bench for seq_mem_playback.
// Cycle c of a run is observed c edges after en_PLAY is first driven high.
module tb_seq_mem_playback;
   import seq_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [7:0] MEM_IN;
   logic       MEM_LOAD;
   seq_idx_t   MEM_LOAD_VAL;
   logic       MEM_CLR;
   seq_idx_t   RD_IDX;
   logic [7:0] RD_DATA;
   logic [3:0] MEM_VALID;
   logic       en_PLAY;
   logic [2:0] PLAY_LEN;
   logic [7:0] PLAY_OUT;
   logic       PLAY_VALID;
   seq_idx_t   PLAY_IDX;
   logic       complete_PLAY;

   int checks = 0;
   int errors = 0;

   seq_mem_playback #(
      .DATA_W(8), .DEPTH(4), .IDX_W(2), .HOLD_CYCLES(4), .GAP_CYCLES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .MEM_IN(MEM_IN), .MEM_LOAD(MEM_LOAD), .MEM_LOAD_VAL(MEM_LOAD_VAL),
      .MEM_CLR(MEM_CLR), .RD_IDX(RD_IDX), .RD_DATA(RD_DATA),
      .MEM_VALID(MEM_VALID), .en_PLAY(en_PLAY), .PLAY_LEN(PLAY_LEN),
      .PLAY_OUT(PLAY_OUT), .PLAY_VALID(PLAY_VALID), .PLAY_IDX(PLAY_IDX),
      .complete_PLAY(complete_PLAY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       load;
      seq_idx_t   idx;
      logic [7:0] din;
      logic       clr;
      seq_idx_t   rd;
      logic [7:0] exp_pre;
      logic [7:0] exp_post;
      logic [3:0] exp_valid;
   } rw_vec_t;

   rw_vec_t    tbl[13];
   logic [7:0] pat[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs playback with en_PLAY held for ncyc cycles, checking every cycle
   // against the show/gap/done windows, then drops en_PLAY.
   task automatic play_run(input logic [2:0] plen, input int eff, input int ncyc);
      int  k, ph, done_at;
      logic show, done;
      en_PLAY  = 1'b1;
      PLAY_LEN = plen;
      chk($sformatf("len%0d c0 valid", plen), 32'(PLAY_VALID), 0);
      done_at = (eff == 0) ? 1 : eff*4 + (eff-1)*2 + 1;
      for (int c = 1; c <= ncyc; c++) begin
         tick();
         k    = (c-1) / 6;
         ph   = (c-1) % 6;
         show = (k < eff) && (ph < 4);
         done = (c >= done_at);
         chk($sformatf("len%0d c%0d valid", plen, c), 32'(PLAY_VALID), 32'(show));
         chk($sformatf("len%0d c%0d out", plen, c), 32'(PLAY_OUT), show ? 32'(pat[k]) : 0);
         chk($sformatf("len%0d c%0d complete", plen, c), 32'(complete_PLAY), 32'(done));
         if (show) chk($sformatf("len%0d c%0d idx", plen, c), 32'(PLAY_IDX), 32'(k));
      end
      en_PLAY = 1'b0;
      tick();
      chk($sformatf("len%0d complete fall", plen), 32'(complete_PLAY), 0);
      chk($sformatf("len%0d idle valid", plen), 32'(PLAY_VALID), 0);
   endtask

   initial begin
      pat[0] = 8'hD8; pat[1] = 8'hC7; pat[2] = 8'hB6; pat[3] = 8'hA5;
      //           load idx din    clr rd  pre    post   valid
      tbl[0]  = '{1'b1, 2'd0, 8'hD8, 1'b0, 2'd0, 8'h00, 8'hD8, 4'b0001};
      tbl[1]  = '{1'b1, 2'd1, 8'hC7, 1'b0, 2'd0, 8'hD8, 8'hD8, 4'b0011};
      tbl[2]  = '{1'b1, 2'd2, 8'hB6, 1'b0, 2'd2, 8'h00, 8'hB6, 4'b0111};
      tbl[3]  = '{1'b1, 2'd3, 8'hA5, 1'b0, 2'd2, 8'hB6, 8'hB6, 4'b1111};
      tbl[4]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd3, 8'hA5, 8'hA5, 4'b1111};
      tbl[5]  = '{1'b1, 2'd1, 8'h55, 1'b0, 2'd1, 8'hC7, 8'h55, 4'b1111};
      tbl[6]  = '{1'b1, 2'd1, 8'hC7, 1'b0, 2'd1, 8'h55, 8'hC7, 4'b1111};
      tbl[7]  = '{1'b1, 2'd1, 8'hC7, 1'b1, 2'd0, 8'hD8, 8'hD8, 4'b0010};
      tbl[8]  = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'hC7, 8'hC7, 4'b0000};
      tbl[9]  = '{1'b1, 2'd0, 8'hD8, 1'b0, 2'd0, 8'hD8, 8'hD8, 4'b0001};
      tbl[10] = '{1'b1, 2'd2, 8'hB6, 1'b0, 2'd3, 8'hA5, 8'hA5, 4'b0101};
      tbl[11] = '{1'b1, 2'd3, 8'hA5, 1'b0, 2'd1, 8'hC7, 8'hC7, 4'b1101};
      tbl[12] = '{1'b1, 2'd1, 8'hC7, 1'b0, 2'd2, 8'hB6, 8'hB6, 4'b1111};

      rst_n = 1'b0; MEM_IN = '0; MEM_LOAD = 1'b0; MEM_LOAD_VAL = '0;
      MEM_CLR = 1'b0; RD_IDX = '0; en_PLAY = 1'b0; PLAY_LEN = '0;
      #12;
      chk("reset valid", 32'(MEM_VALID), 0);
      chk("reset rd", 32'(RD_DATA), 0);
      chk("reset play_out", 32'(PLAY_OUT), 0);
      chk("reset play_valid", 32'(PLAY_VALID), 0);
      chk("reset play_idx", 32'(PLAY_IDX), 0);
      chk("reset complete", 32'(complete_PLAY), 0);
      rst_n = 1'b1;
      tick();

      // Write / clear / random-read vectors.
      for (int i = 0; i < 13; i++) begin
         MEM_LOAD = tbl[i].load; MEM_LOAD_VAL = tbl[i].idx; MEM_IN = tbl[i].din;
         MEM_CLR = tbl[i].clr; RD_IDX = tbl[i].rd;
         #1;
         chk($sformatf("rw%0d rd_pre", i), 32'(RD_DATA), 32'(tbl[i].exp_pre));
         tick();
         chk($sformatf("rw%0d rd_post", i), 32'(RD_DATA), 32'(tbl[i].exp_post));
         chk($sformatf("rw%0d valid", i), 32'(MEM_VALID), 32'(tbl[i].exp_valid));
         MEM_LOAD = 1'b0; MEM_CLR = 1'b0;
      end

      // Full playback, clamped length, zero length.
      play_run(3'd4, 4, 26);
      play_run(3'd7, 4, 26);
      play_run(3'd0, 0, 6);
      play_run(3'd2, 2, 14);

      // Abort mid-show at cycle 9.
      en_PLAY = 1'b1; PLAY_LEN = 3'd4;
      for (int c = 1; c <= 9; c++) tick();
      chk("abort c9 out", 32'(PLAY_OUT), 32'h C7);
      chk("abort c9 valid", 32'(PLAY_VALID), 1);
      en_PLAY = 1'b0;
      tick();
      chk("abort valid", 32'(PLAY_VALID), 0);
      chk("abort out", 32'(PLAY_OUT), 0);
      chk("abort idx", 32'(PLAY_IDX), 0);
      for (int c = 0; c < 20; c++) begin
         tick();
         chk($sformatf("abort complete %0d", c), 32'(complete_PLAY), 0);
      end

      // Overwrite entry 0 while it is on display.
      en_PLAY = 1'b1; PLAY_LEN = 3'd4; RD_IDX = 2'd0;
      tick();
      chk("wshow c1 out", 32'(PLAY_OUT), 32'h D8);
      tick();
      MEM_LOAD = 1'b1; MEM_LOAD_VAL = 2'd0; MEM_IN = 8'h3C;
      tick();
      MEM_LOAD = 1'b0;
      chk("wshow c3 out", 32'(PLAY_OUT), 32'h D8);
      chk("wshow c3 rd", 32'(RD_DATA), 32'h 3C);
      tick();
      chk("wshow c4 out", 32'(PLAY_OUT), 32'h D8);
      tick();
      chk("wshow c5 gap out", 32'(PLAY_OUT), 0);
      chk("wshow c5 gap valid", 32'(PLAY_VALID), 0);
      en_PLAY = 1'b0;
      tick();
      en_PLAY = 1'b1; PLAY_LEN = 3'd1;
      tick();
      chk("wshow rerun out", 32'(PLAY_OUT), 32'h 3C);
      chk("wshow rerun valid", 32'(PLAY_VALID), 1);
      for (int c = 2; c <= 5; c++) tick();
      chk("len1 complete c5", 32'(complete_PLAY), 1);
      en_PLAY = 1'b0;
      tick();

      // Asynchronous reset between edges during a show.
      en_PLAY = 1'b1; PLAY_LEN = 3'd4;
      tick();
      tick();
      chk("areset pre valid", 32'(PLAY_VALID), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("areset play_valid", 32'(PLAY_VALID), 0);
      chk("areset play_out", 32'(PLAY_OUT), 0);
      chk("areset play_idx", 32'(PLAY_IDX), 0);
      chk("areset complete", 32'(complete_PLAY), 0);
      chk("areset mem_valid", 32'(MEM_VALID), 0);
      chk("areset rd", 32'(RD_DATA), 0);
      en_PLAY = 1'b0;
      #1;
      rst_n = 1'b1;
      tick();
      chk("post reset valid", 32'(PLAY_VALID), 0);
      chk("post reset complete", 32'(complete_PLAY), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_mem_playback.md
# seq_mem_playback

Four-entry sequence memory at the receiving end of the memory-load interface driven by the idle/sequence-generation state. It captures bytes written via `MEM_IN`/`MEM_LOAD`/`MEM_LOAD_VAL` and offers two read paths:
- a random-access read port, used by the input-compare stage;
- a timed playback engine that presents the stored pattern to the display, one entry at a time.

## Interface
Parameters:
- `DATA_W`, 8, entry width
- `DEPTH`, 4, number of entries (power of two)
- `IDX_W`, 2, log2(DEPTH)
- `HOLD_CYCLES`, 4, cycles each entry is shown (≥1)
- `GAP_CYCLES`, 2, blank cycles between entries (≥1)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `MEM_IN`  in  DATA_W  write data
- `MEM_LOAD`  in  1  write strobe, one write per cycle high
- `MEM_LOAD_VAL`  in  IDX_W  write index
- `MEM_CLR`  in  1  clear all valid bits
- `RD_IDX`  in  IDX_W  random-read index
- `RD_DATA`  out  DATA_W  combinational read of registered `mem[RD_IDX]`
- `MEM_VALID`  out  DEPTH  per-entry written flag
- `en_PLAY`  in  1  level; start/hold playback
- `PLAY_LEN`  in  IDX_W+1  entries to play, sampled at start
- `PLAY_OUT`  out  DATA_W  displayed entry, 0 when not showing
- `PLAY_VALID`  out  1  high during SHOW
- `PLAY_IDX`  out  IDX_W  index being shown
- `complete_PLAY`  out  1  playback finished

## Operation
- **Reset** (`rst_n`=0, immediate): all mem entries 0, `MEM_VALID`=0, FSM in S_IDLE, `PLAY_OUT`=0, `PLAY_VALID`=0, `PLAY_IDX`=0, `complete_PLAY`=0. A reset mid-playback aborts with no completion.
- **Write:** on an edge with `MEM_LOAD`=1, `mem[MEM_LOAD_VAL]`←`MEM_IN` and `MEM_VALID[MEM_LOAD_VAL]`←1. Writes are accepted in every FSM state.
- **Clear:** `MEM_CLR`=1 zeroes `MEM_VALID`; data is untouched. If `MEM_LOAD` is high in the same cycle, the loaded index's bit ends at 1 and all others at 0.
- **FSM states:** S_IDLE, S_SHOW, S_GAP, S_DONE.
  - S_IDLE, `en_PLAY`=1: latch len = min(`PLAY_LEN`, DEPTH). If len=0, go to S_DONE. Otherwise go to S_SHOW at idx 0.
  - S_SHOW: stays HOLD_CYCLES cycles. Then, if idx=len-1, go to S_DONE; otherwise go to S_GAP.
  - S_GAP: stays GAP_CYCLES cycles, then idx+1 and go to S_SHOW.
  - S_DONE: `complete_PLAY`=1 and holds until `en_PLAY`=0, then return to S_IDLE.
  - `en_PLAY`=0 in S_SHOW or S_GAP: return to S_IDLE next edge and clear outputs; `complete_PLAY` stays 0.
- **Playback data:** `PLAY_OUT` is registered from `mem[idx]` on entry to S_SHOW and held for the whole show. A write to the shown index during SHOW does not change `PLAY_OUT` until that entry is next shown.
- **Valid bits:** `MEM_VALID` does not gate playback; unwritten entries play their stored value.
- **Counters:**
  - Hold/gap counter is wide enough for max(HOLD, GAP).
  - idx increments only on the GAP→SHOW transition and never wraps within a run.

## Timing
- Edge 0 samples `en_PLAY`=1 in S_IDLE. Edge 1 asserts `PLAY_VALID` with `PLAY_OUT`=mem[0] (1-cycle latency).
- Entry k shows during cycles 1+k·(HOLD+GAP) through k·(HOLD+GAP)+HOLD.
- `complete_PLAY` rises at cycle len·HOLD+(len-1)·GAP+1.
- `complete_PLAY` falls one edge after `en_PLAY` falls.
- Write→`RD_DATA` latency is 1 edge. Reading and writing the same index in one cycle returns the old value.
- Re-asserting `en_PLAY` after S_DONE→S_IDLE starts a new run one edge later.

## Structure
- Shared package `seq_pkg`:
  - state enum {S_IDLE, S_SHOW, S_GAP, S_DONE};
  - DATA_W/DEPTH defaults;
  - the `seq_idx_t` typedef.
- One natural sub-module, `seq_mem_regfile`, holds the DEPTH×DATA_W registers, valid bits, write logic and combinational read. The playback FSM and counters live in the top module.

## Test plan
- **Load and read back:** reset, then write D8,C7,B6,A5 to idx 0..3 → `MEM_VALID`=1111 and `RD_IDX`=2 gives B6.
- **Full playback** (HOLD=4, GAP=2, `PLAY_LEN`=4, `en_PLAY` held):
  - D8 shows on cycles 1–4, C7 on 7–10, B6 on 13–16, A5 on 19–22;
  - `PLAY_OUT`=0 during the gaps;
  - `complete_PLAY`=1 from cycle 23 until `en_PLAY` drops.
- **Length edges:**
  - `PLAY_LEN`=0 → `complete_PLAY` at cycle 1, `PLAY_VALID` never high.
  - `PLAY_LEN`=7 → clamped, plays 4 entries.
- **Abort:** drop `en_PLAY` at cycle 9 → next edge returns to S_IDLE with `PLAY_VALID`=0; `complete_PLAY` never asserts.
- **Simultaneous events:**
  - `MEM_CLR` with a load of idx 1 → `MEM_VALID`=0010.
  - Writing 3C to idx 0 during its SHOW keeps `PLAY_OUT`=D8 for the rest of that show.
- **Async reset:** assert `rst_n` low mid-SHOW between clock edges → all outputs 0 immediately and `MEM_VALID`=0.
